debounce_multi: RTL and testbench
=================================

DEBOUNCE_MULTI -- requirements
Module: debounce_multi

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- CH, 4, number of independent switch channels (1..32).
- N, 21, debounce counter bits; stable window is 2^N clocks (2^21 * 20 ns, about 40 ms).
- LONG, 50000000, clocks db_level must stay high before long_tick fires (1 s at 50 MHz); LONG >= 1.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, input, 1, single system clock; all state changes on its rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- sw, input, CH, raw asynchronous switch inputs; bit i is channel i.
- db_level, output, CH, debounced level per channel.
- press_tick, output, CH, one-clock pulse on each debounced 0->1 transition.
- release_tick, output, CH, one-clock pulse on each debounced 1->0 transition.
- long_tick, output, CH, one-clock pulse when a press has been held LONG clocks.
- any_press, output, 1, OR-reduction of press_tick.

Function
REQ-003 Each sw bit SHALL pass through a 2-flop synchronizer; sw_s[i] is the second flop output.
REQ-004 Each channel SHALL have a private FSM with states ZERO, WAIT1, ONE, WAIT0, an N-bit down-counter q, and a long counter wide enough for LONG; channels never interact.
REQ-005 ZERO: db_level=0; sw_s=1 -> WAIT1 with q loaded to 2^N-1.
REQ-006 WAIT1: db_level=0; sw_s=0 -> ZERO, no tick; sw_s=1 and q!=0 -> q decrements; sw_s=1 and q==0 -> ONE.
REQ-007 ONE: db_level=1; sw_s=0 -> WAIT0 with q loaded to 2^N-1.
REQ-008 WAIT0: db_level=1; sw_s=1 -> ONE, no tick; sw_s=0 and q!=0 -> q decrements; sw_s=0 and q==0 -> ZERO.
REQ-009 All outputs SHALL be registered; press_tick is high for exactly the first clock the channel is in ONE after WAIT1; release_tick is high for exactly the first clock in ZERO after WAIT0.
REQ-010 Latency: if sw rises and stays high, db_level SHALL rise after the (2^N+3)-th rising edge, counting the first edge that samples sw high as edge 1; release latency SHALL be identical.
REQ-011 Long counter: cleared in ZERO and WAIT1; increments each clock in ONE or WAIT0 until it reaches LONG, then saturates.
REQ-012 long_tick SHALL pulse for one clock on the clock after the long counter reaches LONG; it fires at most once per debounced press, including when the press bounces through WAIT0 back to ONE.
REQ-013 A release reaching ZERO before LONG SHALL produce no long_tick.
REQ-014 Simultaneous events on different channels SHALL be reported in the same cycle on their own bits; any_press SHALL be registered and aligned with press_tick.
REQ-015 An illegal state encoding SHALL return to ZERO on the next clock with no tick.

Reset
REQ-016 reset_n=0 SHALL immediately force every channel to ZERO, clear q, the long counter and both synchronizer flops, and drive all outputs to 0, independent of clk.
REQ-017 After reset_n is released with sw held high, each such channel SHALL debounce normally and emit press_tick per REQ-010.
REQ-018 Reset asserted mid-WAIT1, mid-WAIT0 or mid-long-count SHALL discard that progress with no pending tick.

Verification (CH=2, N=3, LONG=20)
REQ-019 sw[0] rises and holds -> db_level[0] high and press_tick[0] pulses on edge 11; channel 1 stays idle.
REQ-020 sw[0] high for 5 clocks then low, repeated 4 times -> no press_tick; db_level[0] stays 0.
REQ-021 Held press -> long_tick[0] pulses exactly once, 21 clocks after db_level rises; a 3-clock low glitch mid-hold causes no release_tick and no second long_tick.
REQ-022 sw[0] and sw[1] rise on the same edge -> both press_tick bits and any_press pulse together on edge 11.
REQ-023 Release after a debounced press -> release_tick[0] pulses on edge 11 after sw falls; a release before 20 held clocks gives no long_tick.
REQ-024 reset_n pulsed low while channel 0 is in WAIT1 with q=2 -> all outputs 0 at once; sw still high -> press_tick 11 edges after reset_n deasserts.

Source files
------------

// File: rtl/debounce_multi.sv
// ============================================================================
// debounce_multi
//
// Multi-channel switch debouncer. Every channel is fully independent:
//   raw sw bit -> 2-flop synchronizer -> 4-state debounce FSM with an N-bit
//   stability down-counter -> registered level / edge ticks, plus a
//   saturating "held" counter that produces a single long-press tick.
//
// Parameters
//   CH    number of switch channels (1..32)
//   N     stability counter width; a new level must be seen for 2^N+1
//         consecutive synchronized samples before it is accepted
//   LONG  clocks db_level must remain high before long_tick fires (>= 1)
//
// Ports
//   clk           system clock, rising-edge active
//   reset_n       asynchronous active-low reset
//   sw[CH]        raw asynchronous switch inputs
//   db_level[CH]  debounced level
//   press_tick    one-clock pulse on each debounced 0->1 transition
//   release_tick  one-clock pulse on each debounced 1->0 transition
//   long_tick     one-clock pulse once a press has been held LONG clocks
//   any_press     OR of press_tick, registered in the same cycle
// ============================================================================
module debounce_multi #(
    parameter int CH   = 4,
    parameter int N    = 21,
    parameter int LONG = 50000000
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [CH-1:0] sw,
    output logic [CH-1:0] db_level,
    output logic [CH-1:0] press_tick,
    output logic [CH-1:0] release_tick,
    output logic [CH-1:0] long_tick,
    output logic          any_press
);

    // Long counter must be able to hold the value LONG itself.
    localparam int LW = $clog2(LONG + 1);
    localparam logic [LW-1:0] LONG_V = LW'(LONG);

    // One-hot encoding: the unused encodings give a well-defined illegal
    // space that recovers to ZERO without emitting any tick.
    typedef enum logic [3:0] {
        ZERO  = 4'b0001,
        WAIT1 = 4'b0010,
        ONE   = 4'b0100,
        WAIT0 = 4'b1000
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchronizer, all channels in parallel
    // ------------------------------------------------------------------
    logic [CH-1:0] sync1_reg;
    logic [CH-1:0] sync2_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= sw;
            sync2_reg <= sync1_reg;
        end
    end

    // Per-channel next-cycle press ticks, gathered so any_press can be
    // registered on the same edge as the individual press_tick bits.
    logic [CH-1:0] press_next_vec;

    // ------------------------------------------------------------------
    // Per-channel debounce FSM, stability counter and long-press logic
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            state_t        state_reg, state_next;
            logic [N-1:0]  q_reg, q_next;
            logic [LW-1:0] long_reg, long_next;
            logic          fired_reg, fired_next;
            logic          db_level_reg, db_level_next;
            logic          press_reg, press_next;
            logic          release_reg, release_next;
            logic          long_tick_reg, long_tick_next;
            logic          sw_s;
            logic          in_hold;

            assign sw_s = sync2_reg[gi];

            // Debounced level is 1 exactly in ONE and WAIT0.
            assign in_hold = (state_reg == ONE) || (state_reg == WAIT0);

            // Debounce FSM next-state and tick decode
            always_comb begin
                state_next   = state_reg;
                q_next       = q_reg;
                press_next   = 1'b0;
                release_next = 1'b0;
                case (state_reg)
                    ZERO: begin
                        if (sw_s) begin
                            state_next = WAIT1;
                            q_next     = '1;
                        end
                    end
                    WAIT1: begin
                        if (!sw_s) begin
                            state_next = ZERO;
                        end else if (q_reg != '0) begin
                            q_next = q_reg - N'(1);
                        end else begin
                            state_next = ONE;
                            press_next = 1'b1;
                        end
                    end
                    ONE: begin
                        if (!sw_s) begin
                            state_next = WAIT0;
                            q_next     = '1;
                        end
                    end
                    WAIT0: begin
                        if (sw_s) begin
                            state_next = ONE;
                        end else if (q_reg != '0) begin
                            q_next = q_reg - N'(1);
                        end else begin
                            state_next   = ZERO;
                            release_next = 1'b1;
                        end
                    end
                    default: begin
                        state_next = ZERO;
                        q_next     = '0;
                    end
                endcase
            end

            // Registered level follows the state being entered, so it
            // changes on the same edge as the press/release tick.
            always_comb begin
                db_level_next = (state_next == ONE) || (state_next == WAIT0);
            end

            // Long-press counter: counts clocks spent at debounced level 1,
            // saturating at LONG. fired_reg remembers that this press has
            // already produced its long_tick, so a bounce through WAIT0
            // back to ONE cannot fire a second one. Both clear as soon as
            // the channel is at debounced level 0 (or in an illegal state).
            always_comb begin
                long_next      = '0;
                fired_next     = 1'b0;
                long_tick_next = 1'b0;
                if (in_hold) begin
                    long_tick_next = (long_reg == LONG_V) && !fired_reg;
                    fired_next     = fired_reg | long_tick_next;
                    long_next      = (long_reg == LONG_V) ? long_reg
                                                          : long_reg + LW'(1);
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    state_reg     <= ZERO;
                    q_reg         <= '0;
                    long_reg      <= '0;
                    fired_reg     <= 1'b0;
                    db_level_reg  <= 1'b0;
                    press_reg     <= 1'b0;
                    release_reg   <= 1'b0;
                    long_tick_reg <= 1'b0;
                end else begin
                    state_reg     <= state_next;
                    q_reg         <= q_next;
                    long_reg      <= long_next;
                    fired_reg     <= fired_next;
                    db_level_reg  <= db_level_next;
                    press_reg     <= press_next;
                    release_reg   <= release_next;
                    long_tick_reg <= long_tick_next;
                end
            end

            assign press_next_vec[gi] = press_next;
            assign db_level[gi]       = db_level_reg;
            assign press_tick[gi]     = press_reg;
            assign release_tick[gi]   = release_reg;
            assign long_tick[gi]      = long_tick_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Aggregate press indication, aligned with press_tick
    // ------------------------------------------------------------------
    logic any_press_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            any_press_reg <= 1'b0;
        end else begin
            any_press_reg <= |press_next_vec;
        end
    end

    assign any_press = any_press_reg;

endmodule

// File: tb/tb_debounce_multi.sv
// ============================================================================
// tb_debounce_multi
//
// Bench for debounce_multi with CH=2, N=3, LONG=20. A reference model
// describes each channel by run lengths: the synchronized input must
// disagree with the current debounced level for WIN = 2^N+1 consecutive
// samples before the level flips, and the time spent at level 1 is counted
// (saturating at LONG) to decide the single long-press tick. Directed steps
// cover the named scenarios, then a randomized section exercises bouncy and
// stable inputs against the same model.
// ============================================================================
module tb_debounce_multi;

    localparam int CH   = 2;
    localparam int N    = 3;
    localparam int LONG = 20;
    localparam int WIN  = (1 << N) + 1;

    logic          clk;
    logic          reset_n;
    logic [CH-1:0] sw;
    logic [CH-1:0] db_level;
    logic [CH-1:0] press_tick;
    logic [CH-1:0] release_tick;
    logic [CH-1:0] long_tick;
    logic          any_press;

    int total;
    int bad;

    // Reference model state
    bit            m_s1  [CH];
    bit            m_s2  [CH];
    bit            m_lvl [CH];
    bit            m_fired [CH];
    int            m_run [CH];
    int            m_hold [CH];
    logic [CH-1:0] e_db;
    logic [CH-1:0] e_press;
    logic [CH-1:0] e_rel;
    logic [CH-1:0] e_long;
    logic          e_any;

    debounce_multi #(
        .CH   (CH),
        .N    (N),
        .LONG (LONG)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sw           (sw),
        .db_level     (db_level),
        .press_tick   (press_tick),
        .release_tick (release_tick),
        .long_tick    (long_tick),
        .any_press    (any_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_s1[c]    = 1'b0;
            m_s2[c]    = 1'b0;
            m_lvl[c]   = 1'b0;
            m_fired[c] = 1'b0;
            m_run[c]   = 0;
            m_hold[c]  = 0;
        end
        e_db    = '0;
        e_press = '0;
        e_rel   = '0;
        e_long  = '0;
        e_any   = 1'b0;
    endtask

    // Advance the model by one rising edge using the sw value at that edge.
    task automatic model_edge();
        for (int c = 0; c < CH; c++) begin
            bit was;
            was = m_lvl[c];
            // Long press: judged on the time already held before this edge.
            e_long[c]  = was && (m_hold[c] == LONG) && !m_fired[c];
            m_fired[c] = was ? (m_fired[c] | e_long[c]) : 1'b0;
            m_hold[c]  = was ? ((m_hold[c] >= LONG) ? LONG : m_hold[c] + 1) : 0;
            // Level: flips after WIN consecutive disagreeing samples.
            e_press[c] = 1'b0;
            e_rel[c]   = 1'b0;
            if (m_s2[c] != was) m_run[c]++;
            else                m_run[c] = 0;
            if (m_run[c] == WIN) begin
                m_lvl[c]   = !was;
                m_run[c]   = 0;
                e_press[c] = !was;
                e_rel[c]   = was;
            end
            e_db[c] = m_lvl[c];
            m_s2[c] = m_s1[c];
            m_s1[c] = sw[c];
        end
        e_any = |e_press;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_db"},      32'(db_level),     32'(e_db));
        chk({tag, "_press"},   32'(press_tick),   32'(e_press));
        chk({tag, "_release"}, 32'(release_tick), 32'(e_rel));
        chk({tag, "_long"},    32'(long_tick),    32'(e_long));
        chk({tag, "_any"},     32'(any_press),    32'(e_any));
    endtask

    // One clock: model follows the edge, outputs sampled 1 ns later.
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    // Called just after a checked edge; pulses reset between clock edges.
    task automatic pulse_reset(input string tag);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk({tag, "_db0"},    32'(db_level),     32'h0);
        chk({tag, "_press0"}, 32'(press_tick),   32'h0);
        chk({tag, "_rel0"},   32'(release_tick), 32'h0);
        chk({tag, "_long0"},  32'(long_tick),    32'h0);
        chk({tag, "_any0"},   32'(any_press),    32'h0);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        int nlong;
        int nrel;
        int npress;
        int cd [CH];

        total   = 0;
        bad     = 0;
        sw      = '0;
        reset_n = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset");
        #3;
        reset_n = 1'b1;

        // Single press: level and press tick on edge 11, channel 1 idle
        sw = 2'b01;
        for (int k = 1; k <= 11; k++) begin
            tick("press0");
            if (k < 11) begin
                chk("press0_db_early", 32'(db_level), 32'h0);
            end else begin
                chk("press0_tick_e11", 32'(press_tick), 32'h1);
                chk("press0_db_e11",   32'(db_level),   32'h1);
            end
        end

        // Held press: long_tick 21 clocks after db_level rose
        for (int k = 1; k <= 21; k++) begin
            tick("hold");
            if (k < 21) chk("long_early", 32'(long_tick), 32'h0);
            else        chk("long_at21",  32'(long_tick), 32'h1);
        end

        // 3-clock low glitch mid-hold: no release, no second long tick
        repeat (5) tick("hold2");
        nlong = 0;
        nrel  = 0;
        sw = 2'b00;
        for (int k = 0; k < 3; k++) begin
            tick("glitch");
            nlong += int'(long_tick[0]);
            nrel  += int'(release_tick[0]);
        end
        sw = 2'b01;
        for (int k = 0; k < 40; k++) begin
            tick("glitch_after");
            nlong += int'(long_tick[0]);
            nrel  += int'(release_tick[0]);
        end
        chk("glitch_no_long", 32'(nlong), 32'd0);
        chk("glitch_no_rel",  32'(nrel),  32'd0);
        chk("glitch_db_held", 32'(db_level), 32'h1);

        // Release: release_tick on edge 11 after sw falls
        sw = 2'b00;
        for (int k = 1; k <= 11; k++) begin
            tick("release0");
            if (k < 11) chk("release_db_early", 32'(db_level), 32'h1);
            else        chk("release_e11", 32'(release_tick), 32'h1);
        end

        // Bounce: 5 high / 5 low, four times -> nothing accepted
        npress = 0;
        for (int r = 0; r < 4; r++) begin
            sw = 2'b01;
            for (int k = 0; k < 5; k++) begin
                tick("bounce_hi");
                npress += int'(press_tick[0]);
            end
            sw = 2'b00;
            for (int k = 0; k < 5; k++) begin
                tick("bounce_lo");
                npress += int'(press_tick[0]);
            end
        end
        chk("bounce_no_press", 32'(npress), 32'd0);
        chk("bounce_db_low",   32'(db_level), 32'h0);
        repeat (12) tick("settle");

        // Short press: release before LONG held clocks -> no long tick
        nlong = 0;
        sw = 2'b01;
        for (int k = 0; k < 11; k++) begin
            tick("short_press");
            nlong += int'(long_tick[0]);
        end
        sw = 2'b00;
        for (int k = 0; k < 30; k++) begin
            tick("short_release");
            nlong += int'(long_tick[0]);
        end
        chk("short_no_long", 32'(nlong), 32'd0);

        // Both channels on the same edge
        sw = 2'b11;
        for (int k = 1; k <= 11; k++) begin
            tick("dual");
            if (k == 11) begin
                chk("dual_press", 32'(press_tick), 32'h3);
                chk("dual_any",   32'(any_press),  32'h1);
            end
        end
        sw = 2'b00;
        repeat (14) tick("dual_rel");

        // Reset mid-WAIT1: channel 1 debounced high, channel 0 with q=2
        sw = 2'b10;
        repeat (11) tick("pre_rst_ch1");
        sw = 2'b11;
        repeat (8) tick("pre_rst_ch0");
        chk("pre_rst_db", 32'(db_level), 32'h2);
        pulse_reset("mid_wait1");
        for (int k = 1; k <= 11; k++) begin
            tick("post_rst");
            if (k < 11) chk("post_rst_early", 32'(press_tick), 32'h0);
            else        chk("post_rst_e11",   32'(press_tick), 32'h3);
        end
        sw = 2'b00;
        repeat (14) tick("post_rst_rel");

        // Randomized: mix of short bounces and long stable periods
        cd[0] = 3;
        cd[1] = 7;
        for (int t = 0; t < 800; t++) begin
            for (int c = 0; c < CH; c++) begin
                if (cd[c] == 0) begin
                    sw[c] = ~sw[c];
                    cd[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(12, 45))
                                                        : int'($urandom_range(1, 6));
                end else begin
                    cd[c]--;
                end
            end
            if (t == 400) pulse_reset("rand_rst");
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
